// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song ROM walker that feeds notes to the note player
// Fetches one 16-bit word per note, pulses o_load, then holds for the note's duration in ticks.

module note_sequencer #(
  parameter int ADDR_W  = 8,
  parameter bit LOOP_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_song_base,
  input  logic              i_player_done,
  output logic              o_load,
  output logic [5:0]        o_pitch,
  output logic [4:0]        o_duration,
  output logic [3:0]        o_instrument,
  output logic              o_playing,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                load_q, load_d;
  logic [5:0]          pitch_q, pitch_d;
  logic [4:0]          dur_q, dur_d;
  logic [3:0]          instr_q, instr_d;
  logic                last_q, last_d;
  logic [4:0]          tick_cnt_q, tick_cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      load_q     <= 1'b0;
      pitch_q    <= '0;
      dur_q      <= '0;
      instr_q    <= '0;
      last_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      load_q     <= load_d;
      pitch_q    <= pitch_d;
      dur_q      <= dur_d;
      instr_q    <= instr_d;
      last_q     <= last_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    load_d     = 1'b0;
    pitch_d    = pitch_q;
    dur_d      = dur_q;
    instr_d    = instr_q;
    last_d     = last_q;
    tick_cnt_d = tick_cnt_q;

    // Stop outranks everything, including a simultaneous start in IDLE.
    if (i_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            base_d  = i_song_base;
            addr_d  = i_song_base;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          pitch_d = i_rom_data[15:10];
          dur_d   = i_rom_data[9:5];
          instr_d = i_rom_data[4:1];
          last_d  = i_rom_data[0];
          load_d  = 1'b1;
          state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_player_done) begin
            tick_cnt_d = dur_q;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A tick seen with the counter at zero is the note's final tick.
          if (i_tick) begin
            if (tick_cnt_q != 5'd0) begin
              tick_cnt_d = tick_cnt_q - 5'd1;
            end else if (!last_q) begin
              addr_d  = addr_q + ADDR_ONE;
              state_d = ST_FETCH;
            end else if (LOOP_EN) begin
              addr_d  = base_q;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign o_load       = load_q;
  assign o_pitch      = pitch_q;
  assign o_duration   = dur_q;
  assign o_instrument = instr_q;
  assign o_rom_addr   = addr_q;
  assign o_playing    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer, looping and one-shot instances
// Both instances share stimulus; each has its own ROM port and expected-load queue.

module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  base = 8'h00;
  logic        done = 1'b0;

  logic        load_a, load_b;
  logic [5:0]  pitch_a, pitch_b;
  logic [4:0]  dur_a, dur_b;
  logic [3:0]  instr_a, instr_b;
  logic        playing_a, playing_b;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] rom_a, rom_b;

  logic [15:0] rom [256];
  logic [14:0] q_a [$];
  logic [14:0] q_b [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_sequencer #(.ADDR_W(8), .LOOP_EN(1'b1)) u_loop (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start(start), .i_stop(stop),
    .i_song_base(base), .i_player_done(done), .o_load(load_a), .o_pitch(pitch_a),
    .o_duration(dur_a), .o_instrument(instr_a), .o_playing(playing_a),
    .o_rom_addr(addr_a), .i_rom_data(rom_a)
  );

  note_sequencer #(.ADDR_W(8), .LOOP_EN(1'b0)) u_once (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start(start), .i_stop(stop),
    .i_song_base(base), .i_player_done(done), .o_load(load_b), .o_pitch(pitch_b),
    .o_duration(dur_b), .o_instrument(instr_b), .o_playing(playing_b),
    .o_rom_addr(addr_b), .i_rom_data(rom_b)
  );

  always @(posedge clk) begin
    rom_a <= rom[addr_a];
    rom_b <= rom[addr_b];
  end

  function automatic logic [15:0] word(input logic [5:0] p, input logic [4:0] d,
                                       input logic [3:0] i, input logic l);
    return {p, d, i, l};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_both(input logic [5:0] p, input logic [4:0] d, input logic [3:0] i);
    q_a.push_back({p, d, i});
    q_b.push_back({p, d, i});
  endtask

  task automatic exp_loop(input logic [5:0] p, input logic [4:0] d, input logic [3:0] i);
    q_a.push_back({p, d, i});
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (load_a) begin
        if (q_a.size() == 0) chk("loop_unexpected_load", {17'd0, pitch_a, dur_a, instr_a}, 32'hFFFF_FFFF);
        else chk("loop_load_fields", {17'd0, pitch_a, dur_a, instr_a}, {17'd0, q_a.pop_front()});
      end
      if (load_b) begin
        if (q_b.size() == 0) chk("once_unexpected_load", {17'd0, pitch_b, dur_b, instr_b}, 32'hFFFF_FFFF);
        else chk("once_load_fields", {17'd0, pitch_b, dur_b, instr_b}, {17'd0, q_b.pop_front()});
      end
    end
  endtask

  task automatic pulse_start(input logic [7:0] b);
    start = 1'b1;
    base  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_load(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (load_a) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("wait_load_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic stimulus();
    int lat;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[8'h10] = word(6'h21, 5'd2,  4'd5, 1'b0);
    rom[8'h11] = word(6'h05, 5'd0,  4'd1, 1'b0);
    rom[8'h12] = word(6'h3F, 5'd1,  4'hF, 1'b1);
    rom[8'h20] = word(6'h0A, 5'd31, 4'd3, 1'b1);
    rom[8'hFF] = word(6'h11, 5'd0,  4'd2, 1'b0);
    rom[8'h00] = word(6'h01, 5'd3,  4'd9, 1'b1);

    repeat (3) @(negedge clk);
    chk("reset_load", {31'd0, load_a}, 32'd0);
    chk("reset_playing", {31'd0, playing_a}, 32'd0);
    chk("reset_addr", {24'd0, addr_a}, 32'd0);
    chk("reset_fields", {17'd0, pitch_a, dur_a, instr_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic note and done gating
    exp_both(6'h21, 5'd2, 4'd5);
    pulse_start(8'h10);
    chk("start_addr", {24'd0, addr_a}, 32'h10);
    chk("start_playing", {31'd0, playing_a}, 32'd1);
    wait_load(lat);
    chk("start_to_load_cycles", lat + 1, 32'd3);
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("gated_addr", {24'd0, addr_a}, 32'h10);
    chk("gated_playing", {31'd0, playing_a}, 32'd1);
    done = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    done = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    do_tick();
    do_tick();
    chk("dur2_after_2_ticks", {24'd0, addr_a}, 32'h10);
    do_tick();
    chk("dur2_after_3_ticks", {24'd0, addr_a}, 32'h11);

    // Duration 0 note
    exp_both(6'h05, 5'd0, 4'd1);
    wait_load(lat);
    pulse_done();
    chk("dur0_before_tick", {24'd0, addr_a}, 32'h11);
    do_tick();
    chk("dur0_after_1_tick", {24'd0, addr_a}, 32'h12);

    // Last note: loop vs one-shot
    exp_both(6'h3F, 5'd1, 4'hF);
    wait_load(lat);
    pulse_done();
    do_tick();
    chk("last_mid_loop_addr", {24'd0, addr_a}, 32'h12);
    chk("last_mid_once_playing", {31'd0, playing_b}, 32'd1);
    exp_loop(6'h21, 5'd2, 4'd5);
    do_tick();
    chk("loop_wrap_addr", {24'd0, addr_a}, 32'h10);
    chk("loop_still_playing", {31'd0, playing_a}, 32'd1);
    chk("once_idle_at_end", {31'd0, playing_b}, 32'd0);
    chk("once_addr_held", {24'd0, addr_b}, 32'h12);
    wait_load(lat);
    pulse_done();
    do_tick();
    pulse_stop();
    chk("stop_in_hold_playing", {31'd0, playing_a}, 32'd0);
    chk("stop_keeps_pitch", {26'd0, pitch_a}, 32'h21);

    // Start and stop together from IDLE
    start = 1'b1;
    stop  = 1'b1;
    base  = 8'h20;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_playing", {31'd0, playing_a}, 32'd0);
    repeat (5) @(negedge clk);
    chk("start_stop_still_idle", {31'd0, playing_a}, 32'd0);
    chk("start_stop_addr", {24'd0, addr_a}, 32'h10);

    // Duration 31 lasts 32 ticks
    exp_both(6'h0A, 5'd31, 4'd3);
    pulse_start(8'h20);
    wait_load(lat);
    pulse_done();
    repeat (31) do_tick();
    chk("dur31_after_31_once", {31'd0, playing_b}, 32'd1);
    exp_loop(6'h0A, 5'd31, 4'd3);
    do_tick();
    chk("dur31_after_32_once", {31'd0, playing_b}, 32'd0);
    chk("dur31_after_32_loop", {31'd0, playing_a}, 32'd1);
    wait_load(lat);
    pulse_stop();

    // Address wrap at 0xFF, then reset in WAIT_DONE
    exp_both(6'h11, 5'd0, 4'd2);
    pulse_start(8'hFF);
    wait_load(lat);
    pulse_done();
    do_tick();
    chk("wrap_addr_loop", {24'd0, addr_a}, 32'h00);
    chk("wrap_addr_once", {24'd0, addr_b}, 32'h00);
    exp_both(6'h01, 5'd3, 4'd9);
    wait_load(lat);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midnote_reset_playing", {30'd0, playing_a, playing_b}, 32'd0);
    chk("midnote_reset_fields", {17'd0, pitch_a, dur_a, instr_a}, 32'd0);
    chk("midnote_reset_load", {30'd0, load_a, load_b}, 32'd0);
    chk("midnote_reset_addr", {24'd0, addr_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("loop_queue_drained", q_a.size(), 32'd0);
    chk("once_queue_drained", q_b.size(), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream feeder for the note player.
- Walks a song pattern stored in ROM, one 16-bit word per note, and presents pitch/duration/instrument with a one-cycle load pulse.
- Waits for the player's done pulse, then holds each note for its duration in ticks before fetching the next word.
- Supports start/stop, an end-of-song flag, and optional looping.

Parameters:
- ADDR_W, 8, width of song ROM address.
- LOOP_EN, 1, 1 = on end flag, wrap to latched song base; 0 = stop and return to IDLE.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  one-cycle frame tick.
- i_start  in  1  pulse: begin playback at i_song_base.
- i_stop  in  1  pulse: abort playback.
- i_song_base  in  ADDR_W  first word address; latched on i_start.
- i_player_done  in  1  one-cycle pulse from the note player after it has consumed a load.
- o_load  out  1  one-cycle pulse; note fields are valid while it is high.
- o_pitch  out  6  note pitch.
- o_duration  out  5  note duration code.
- o_instrument  out  4  instrument index.
- o_playing  out  1  high in every state except IDLE.
- o_rom_addr  out  ADDR_W  song ROM address, registered.
- i_rom_data  in  16  song ROM data; valid one cycle after o_rom_addr.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - o_load=0, o_pitch=0, o_duration=0, o_instrument=0, o_playing=0, o_rom_addr=0.
  - Base, address and tick counter cleared.
- Word format:
  - [15:10] pitch.
  - [9:5] duration.
  - [4:1] instrument.
  - [0] last-note flag.
- IDLE: on i_start, latch base; o_rom_addr<=i_song_base; go to FETCH.
- FETCH: one wait cycle for ROM latency; go to CAPTURE.
- CAPTURE:
  - Register pitch, duration and instrument fields into the outputs.
  - Record the last flag.
  - o_load<=1 (high exactly one cycle, in the following cycle).
  - Go to WAIT_DONE.
- WAIT_DONE: remain until i_player_done=1; then tick_cnt<=o_duration; go to HOLD.
- HOLD: each i_tick decrements tick_cnt. An i_tick seen while tick_cnt==0 ends the note:
  - last flag=0: o_rom_addr<=o_rom_addr+1 (wraps modulo 2^ADDR_W); go to FETCH.
  - last flag=1 and LOOP_EN=1: o_rom_addr<=latched base; go to FETCH.
  - last flag=1 and LOOP_EN=0: go to IDLE.
- Note length:
  - Duration code d lasts d+1 ticks, counted from the first tick after i_player_done.
  - d=0 is 1 tick; d=31 is 32 ticks.
- Load-to-load latency: i_start to o_load = 3 cycles (FETCH, CAPTURE, then o_load cycle).
- Ignored events:
  - i_tick outside HOLD is ignored, including a tick coincident with i_player_done.
  - i_player_done outside WAIT_DONE is ignored.
  - i_start outside IDLE is ignored.
- Stop:
  - i_stop in any non-IDLE state goes to IDLE next cycle and forces o_load=0.
  - i_stop has priority over all other events.
  - Note output fields keep their last values.
- i_start and i_stop in the same cycle in IDLE: stop wins; stay in IDLE.
- Reset asserted mid-note: immediate return to reset values; no o_load is emitted.
- o_playing=1 in FETCH, CAPTURE, WAIT_DONE and HOLD.
- Undefined state encodings recover to IDLE.

Test Plan:
- Basic note:
  - ROM[0x10]={pitch 0x21, dur 2, instr 5, last 0}.
  - i_start, base 0x10.
  - Expect o_rom_addr=0x10, then o_load pulse 3 cycles after start with pitch 0x21, duration 2, instrument 5.
  - After done, 3 ticks, then o_rom_addr=0x11.
- Done gating: withhold i_player_done for 20 cycles while 5 ticks arrive -> no address advance; duration counting begins only after the done pulse.
- End of song, LOOP_EN=1:
  - ROM[0x10..0x12], last flag set on 0x12.
  - Expect loads from 0x10, 0x11, 0x12, then 0x10 again.
- End of song, LOOP_EN=0: same ROM -> after the 0x12 note's final tick, o_playing=0 and no fourth o_load.
- Stop and reset:
  - i_stop during HOLD -> IDLE next cycle, o_playing=0.
  - Start and stop in the same cycle from IDLE -> remains IDLE.
  - Reset asserted during WAIT_DONE -> all outputs 0 immediately.
- Boundaries:
  - Duration 0 -> note lasts exactly 1 tick.
  - Duration 31 -> exactly 32 ticks.
  - Base 0xFF with last=0 -> next fetch at 0x00.
